// File: rtl/data_demod_if.sv
// Symbol-in / byte-out bus of the nibble-pair demodulator.
// The master side drives symbols and pops; the slave side is the demodulator.
interface data_demod_if;
    logic        mod_en;
    logic [4:0]  dmod;
    logic        rd;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        full;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] byte_cnt;
    logic [7:0]  err_cnt;

    modport master (
        output mod_en, dmod, rd,
        input  data_out, data_valid, full, err, err_code, byte_cnt, err_cnt
    );

    modport slave (
        input  mod_en, dmod, rd,
        output data_out, data_valid, full, err, err_code, byte_cnt, err_cnt
    );
endinterface

// File: rtl/data_demod_fsm.sv
// Reassembles bytes from high/low nibble symbol pairs into a show-ahead FIFO.
// Framing errors, timeouts and overflows raise a one-cycle err pulse and are counted.
module data_demod_fsm #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input logic        clk,
    input logic        reset,
    data_demod_if.slave bus
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT + 1);

    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
    localparam logic [ToW-1:0]  ToLimit = ToW'(TIMEOUT);

    localparam logic [1:0] ErrOrphan   = 2'b00;
    localparam logic [1:0] ErrDupHi    = 2'b01;
    localparam logic [1:0] ErrTimeout  = 2'b10;
    localparam logic [1:0] ErrOverflow = 2'b11;

    typedef enum logic [0:0] {StWaitHi, StWaitLo} state_e;

    state_e          state_q, state_d;
    logic [3:0]      hi_q, hi_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic [ToW-1:0]  to_cnt_inc;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      data_out_q, data_out_d;

    logic            err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [15:0]     byte_cnt_q, byte_cnt_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic            sym_hi, sym_lo;
    logic [3:0]      nibble;
    logic            push_req, push, pop;
    logic [7:0]      push_byte;
    logic            fsm_err;
    logic [1:0]      fsm_code;

    assign sym_hi     = bus.mod_en & bus.dmod[4];
    assign sym_lo     = bus.mod_en & ~bus.dmod[4];
    assign nibble     = bus.dmod[3:0];
    assign to_cnt_inc = to_cnt_q + 1'b1;

    // Symbol framing FSM.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        to_cnt_d  = to_cnt_q;
        push_req  = 1'b0;
        push_byte = '0;
        fsm_err   = 1'b0;
        fsm_code  = ErrOrphan;
        unique case (state_q)
            StWaitHi: begin
                if (sym_hi) begin
                    hi_d     = nibble;
                    to_cnt_d = '0;
                    state_d  = StWaitLo;
                end else if (sym_lo) begin
                    fsm_err  = 1'b1;
                    fsm_code = ErrOrphan;
                end
            end
            StWaitLo: begin
                if (sym_lo) begin
                    push_req  = 1'b1;
                    push_byte = {hi_q, nibble};
                    to_cnt_d  = '0;
                    state_d   = StWaitHi;
                end else if (sym_hi) begin
                    hi_d     = nibble;
                    to_cnt_d = '0;
                    fsm_err  = 1'b1;
                    fsm_code = ErrDupHi;
                end else if (to_cnt_inc == ToLimit) begin
                    to_cnt_d = '0;
                    fsm_err  = 1'b1;
                    fsm_code = ErrTimeout;
                    state_d  = StWaitHi;
                end else begin
                    to_cnt_d = to_cnt_inc;
                end
            end
            default: state_d = StWaitHi;
        endcase
    end

    // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
    assign pop  = bus.rd & (count_q != '0);
    assign push = push_req & ((count_q != FullCnt) | pop);

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // The new head may be the byte being written this edge, so bypass the array.
        data_out_d = data_out_q;
        if (count_d != '0) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
                data_out_d = push_byte;
            end else begin
                data_out_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_comb begin
        err_d      = fsm_err;
        err_code_d = fsm_code;
        if (push_req && !push) begin
            err_d      = 1'b1;
            err_code_d = ErrOverflow;
        end
        byte_cnt_d = push ? byte_cnt_q + 16'd1 : byte_cnt_q;
        err_cnt_d  = (err_d && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StWaitHi;
            hi_q       <= '0;
            to_cnt_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            byte_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            to_cnt_q   <= to_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            byte_cnt_q <= byte_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= push_byte;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = (count_q != '0);
    assign bus.full       = (count_q == FullCnt);
    assign bus.err        = err_q;
    assign bus.err_code   = err_code_q;
    assign bus.byte_cnt   = byte_cnt_q;
    assign bus.err_cnt    = err_cnt_q;

    occupancy_in_range: assert property (@(posedge clk) disable iff (reset) count_q <= FullCnt);

endmodule

// File: doc/data_demod_fsm.md
Name: data_demod_fsm

Overview:
Receive-side counterpart of data_mod_fsm. Accepts the 5-bit modulated symbol stream (dmod, qualified by mod_en) and reassembles 8-bit bytes from high/low nibble symbol pairs. Completed bytes are buffered in a small show-ahead FIFO read by downstream logic via rd. Framing errors, timeouts and overflows are flagged and counted.

Parameters:
FIFO_DEPTH, 4, output FIFO entries; power of 2, minimum 2.
TIMEOUT, 16, idle cycles allowed in WAIT_LO before the partial byte is aborted; minimum 1.

Ports:
clk  input  1  clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
mod_en  input  1  dmod valid this cycle.
dmod  input  5  symbol: [4]=1 high nibble (first), [4]=0 low nibble (second); [3:0]=nibble.
rd  input  1  downstream pop; ignored when data_valid=0.
data_out  output  8  FIFO head byte; valid when data_valid=1.
data_valid  output  1  FIFO not empty.
full  output  1  FIFO holds FIFO_DEPTH entries.
err  output  1  one-cycle error pulse.
err_code  output  2  valid with err: 00 orphan low, 01 duplicate high, 10 timeout, 11 overflow.
byte_cnt  output  16  bytes pushed into FIFO; wraps at 0xFFFF->0.
err_cnt  output  8  err pulses; saturates at 0xFF.

Behaviour:
- Reset (reset=1 at posedge): state=WAIT_HI, FIFO emptied; data_valid=0, full=0, data_out=0, err=0, err_code=0, byte_cnt=0, err_cnt=0, timeout counter=0. Reset overrides every other input, including mid-byte and mid-pop.
- Symbols are sampled only at a posedge with mod_en=1. dmod is don't-care when mod_en=0.
- State WAIT_HI:
  - High symbol: latch nibble into hi_reg, clear timeout counter, go to WAIT_LO.
  - Low symbol: discard it, err=1, err_code=00, stay in WAIT_HI.
  - No symbol: stay.
- State WAIT_LO:
  - Low symbol: byte={hi_reg, nibble}; push to FIFO; go to WAIT_HI.
  - High symbol: overwrite hi_reg with the new nibble, err=1, err_code=01, stay in WAIT_LO, clear timeout counter.
  - No symbol: increment timeout counter. When the counter reaches TIMEOUT, drop hi_reg, err=1, err_code=10, go to WAIT_HI.
- Push:
  - Accepted if the FIFO is not full, or if it is full and rd=1 with data_valid=1 in the same cycle (pop and push together; occupancy unchanged).
  - Otherwise the byte is dropped, err=1, err_code=11, byte_cnt unchanged.
  - An accepted push increments byte_cnt the same edge.
- Latency: a low symbol sampled at edge N gives data_valid=1 and data_out=byte after edge N (visible in cycle N+1) when the FIFO was empty. There is no combinational path from dmod to data_out.
- FIFO:
  - Show-ahead; data_out is registered from the head entry.
  - rd with data_valid=1 pops at the edge; the next entry appears after that edge.
  - Pop and push on an empty FIFO cannot coincide, because data_valid=0 blocks the pop.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - full and data_valid are derived from the occupancy count, which ranges 0..FIFO_DEPTH.
  - data_out holds its last value when the FIFO is empty.
- Error events are mutually exclusive by construction: at most one err per cycle. err_cnt increments on each err until it reaches 0xFF, then holds.
- byte_cnt and err_cnt are not cleared by anything except reset.

Test Plan:
1. Basic pair, FIFO empty: reset for 2 cycles; hi=0x13, then next cycle lo=0x05 -> data_valid=1 with data_out=0x35 one cycle after the lo symbol; byte_cnt=1; err never asserted. Then rd=1 for one cycle -> data_valid=0.
2. Back-to-back streaming: bytes 0x00..0x09 (same increment pattern the modulator bench uses), sent as 20 consecutive symbols, with rd=1 held -> 10 bytes read in order 0x00..0x09; byte_cnt=10; full never asserted.
3. Framing errors:
   - lo=0x0A while in WAIT_HI -> err=1, err_code=00, no push.
   - hi=0x1, hi=0x2, lo=0x3 -> err_code=01 on the second hi; byte 0x23 pushed.
   - err_cnt=2 at the end.
4. Timeout: hi=0x1 followed by 16 idle cycles -> err=1, err_code=10 on the 16th idle edge; state returns to WAIT_HI. A following lo=0x4 gives err_code=00.
5. Overflow: rd=0; push 5 bytes 0xA0..0xA4 with FIFO_DEPTH=4 -> full=1 after the 4th byte; 5th byte dropped with err_code=11; byte_cnt=4. Then drain -> 0xA0..0xA3 in order. Repeat with rd=1 on the 5th push's cycle -> byte accepted, no err.
6. Reset mid-operation: hi=0x7 then reset=1 for one cycle, FIFO holding 2 bytes -> all outputs return to reset values; a following lo=0x1 gives err_code=00; err_cnt=1.
